// File: rtl/enc_pkg.sv
// Shared encoder definitions: channel count, sample width, sample type and
// filter FSM states. The ADC reader and the DSP bus decoder also use this package.
package enc_pkg;

    localparam int ENC_NCH = 16;
    localparam int ENC_DW  = 16;

    typedef logic signed [ENC_DW-1:0] enc_sample_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PROC = 2'd1,
        SWAP = 2'd2
    } enc_state_t;

endpackage

// File: rtl/enc_hist_ram.sv
// Sample history store for the moving-average filter.
// Holds NCH channels x 2**LOG2_DEPTH slots. It has one write port and an
// asynchronous read port. Reset clears every entry, so the filter starts
// from a zero-filled window.
module enc_hist_ram #(
    parameter int NCH        = 16,
    parameter int DW         = 16,
    parameter int LOG2_DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    we,
    input  logic [$clog2(NCH)-1:0]  wr_ch,
    input  logic [LOG2_DEPTH-1:0]   wr_slot,
    input  logic [DW-1:0]           wr_data,
    input  logic [$clog2(NCH)-1:0]  rd_ch,
    input  logic [LOG2_DEPTH-1:0]   rd_slot,
    output logic [DW-1:0]           rd_data
);

    localparam int ENTRIES = NCH << LOG2_DEPTH;

    logic [DW-1:0] mem [ENTRIES];

    // Write the new sample into its channel/slot; reset zeroes the whole window
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[{wr_ch, wr_slot}] <= wr_data;
        end
    end

    assign rd_data = mem[{rd_ch, rd_slot}];

endmodule

// File: rtl/enc_avg_filter.sv
// Per-channel moving-average filter for the absolute-encoder snapshot.
// The block captures a full snapshot and filters one channel per cycle into
// the work bank. It then swaps banks, so the DSP only ever reads complete frames.
module enc_avg_filter
    import enc_pkg::*;
#(
    parameter int NCH      = ENC_NCH,
    parameter int DW       = ENC_DW,
    parameter int LOG2_WIN = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              smp_valid,
    input  logic [NCH*DW-1:0] smp_data,
    input  logic              rd_en,
    input  logic [3:0]        rd_addr,
    output logic [DW-1:0]     rd_data,
    output logic              frame_rdy,
    output logic [7:0]        frame_cnt,
    output logic              warm,
    output logic              overrun,
    input  logic              clr_ovr
);

    localparam int CHW = $clog2(NCH);
    localparam int SW  = DW + LOG2_WIN;
    localparam logic [LOG2_WIN:0] WIN_CNT = (LOG2_WIN+1)'(1 << LOG2_WIN);

    enc_state_t            state;
    logic [CHW-1:0]        ch;
    logic [NCH*DW-1:0]     cap_reg;
    logic [LOG2_WIN-1:0]   wptr;
    logic                  pub_sel;
    logic [LOG2_WIN:0]     fill;

    logic [SW-1:0]         sum_q [NCH];
    logic [DW-1:0]         bank0 [NCH];
    logic [DW-1:0]         bank1 [NCH];

    logic [DW-1:0]         new_smp;
    logic [DW-1:0]         old_smp;
    logic [SW-1:0]         sum_next;
    logic [DW-1:0]         avg_next;
    logic                  proc_act;

    assign proc_act = (state == PROC);
    assign new_smp  = cap_reg[ch*DW +: DW];

    // The sum is widened by LOG2_WIN bits, so a full window of DW-bit samples cannot overflow it.
    // Two's-complement wrap gives the same bits whether the operands are signed or unsigned.
    assign sum_next = sum_q[ch]
                    + {{LOG2_WIN{new_smp[DW-1]}}, new_smp}
                    - {{LOG2_WIN{old_smp[DW-1]}}, old_smp};

    // Taking the upper DW bits is an arithmetic shift right by LOG2_WIN, which rounds toward -inf.
    assign avg_next = sum_next[SW-1:LOG2_WIN];

    enc_hist_ram #(
        .NCH        (NCH),
        .DW         (DW),
        .LOG2_DEPTH (LOG2_WIN)
    ) u_hist (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (proc_act),
        .wr_ch   (ch),
        .wr_slot (wptr),
        .wr_data (new_smp),
        .rd_ch   (ch),
        .rd_slot (wptr),
        .rd_data (old_smp)
    );

    // Frame sequencing: capture, walk the channels, publish, plus status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ch        <= '0;
            cap_reg   <= '0;
            wptr      <= '0;
            pub_sel   <= 1'b0;
            fill      <= '0;
            frame_rdy <= 1'b0;
            frame_cnt <= '0;
            warm      <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_rdy <= 1'b0;

            if (smp_valid && (state != IDLE)) begin
                overrun <= 1'b1;
            end else if (clr_ovr) begin
                overrun <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (smp_valid) begin
                        cap_reg <= smp_data;
                        ch      <= '0;
                        state   <= PROC;
                    end
                end
                PROC: begin
                    ch <= ch + 1'b1;
                    if (ch == CHW'(NCH-1)) begin
                        state <= SWAP;
                    end
                end
                SWAP: begin
                    wptr      <= wptr + 1'b1;
                    pub_sel   <= ~pub_sel;
                    frame_rdy <= 1'b1;
                    frame_cnt <= frame_cnt + 8'd1;
                    if (fill != WIN_CNT) begin
                        fill <= fill + 1'b1;
                    end
                    if (fill >= WIN_CNT - 1'b1) begin
                        warm <= 1'b1;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Running sums and the work bank (the bank the DSP is not currently reading)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                sum_q[i] <= '0;
                bank0[i] <= '0;
                bank1[i] <= '0;
            end
        end else if (proc_act) begin
            sum_q[ch] <= sum_next;
            if (pub_sel) begin
                bank0[ch] <= avg_next;
            end else begin
                bank1[ch] <= avg_next;
            end
        end
    end

    // Registered DSP read from the published bank; the value holds while rd_en is low
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= pub_sel ? bank1[rd_addr] : bank0[rd_addr];
        end
    end

endmodule
